// File: rtl/ndata_packet_arbiter_if.sv
// ndata stream bundle: one beat of NUM_ELEMENTS elements with per-element keep
// and a packet-end flag, handshaked by valid/ready.
interface ndata_i #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 4
);
    logic                     valid;
    logic                     ready;
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;

    modport m (output valid, data, keep, last, input ready);
    modport s (input valid, data, keep, last, output ready);
endinterface

// File: rtl/ndata_packet_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared stateful ndata consumer.
// Sources switch only on last boundaries; each grant's source index is queued for the demux.
module ndata_packet_arbiter #(
    parameter type data_t        = logic [7:0],
    parameter int  NUM_ELEMENTS  = 4,
    parameter int  NUM_INPUTS    = 2,
    parameter int  ID_FIFO_DEPTH = 8,
    localparam int ID_W          = $clog2(NUM_INPUTS)
) (
    input  logic            clk,
    input  logic            rst_n,
    ndata_i.s               in [NUM_INPUTS],
    ndata_i.m               out,
    output logic [ID_W-1:0] id_data,
    output logic            id_valid,
    input  logic            id_ready
);

    localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_INPUTS - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] sel_next;
    logic [ID_W-1:0] prio;
    logic [ID_W-1:0] prio_next;

    logic                     in_valid [NUM_INPUTS];
    data_t [NUM_ELEMENTS-1:0] in_data  [NUM_INPUTS];
    logic  [NUM_ELEMENTS-1:0] in_keep  [NUM_INPUTS];
    logic                     in_last  [NUM_INPUTS];

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic            grant;
    logic            last_accepted;

    logic [ID_W-1:0]  fifo_mem [ID_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Interface arrays only allow constant indices, so flatten them into plain arrays.
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
        assign in_valid[g] = in[g].valid;
        assign in_data[g]  = in[g].data;
        assign in_keep[g]  = in[g].keep;
        assign in_last[g]  = in[g].last;
        assign in[g].ready = (state == LOCKED) && (sel == ID_W'(g)) && out.ready;
    end

    // Rotating scan starting at prio; explicit wrap keeps non-power-of-two counts correct.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = prio;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    assign fifo_full     = (count == CNT_W'(ID_FIFO_DEPTH));
    assign grant         = (state == IDLE) && grant_found && !fifo_full;
    assign last_accepted = (state == LOCKED) && in_valid[sel] && out.ready && in_last[sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            prio  <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            prio  <= prio_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        prio_next  = prio;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = LOCKED;
                    sel_next   = grant_idx;
                    prio_next  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end
            end
            LOCKED: begin
                if (last_accepted) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out.valid = 1'b0;
        out.data  = '0;
        out.keep  = '0;
        out.last  = 1'b0;
        if (state == LOCKED) begin
            out.valid = in_valid[sel];
            out.data  = in_data[sel];
            out.keep  = in_keep[sel];
            out.last  = in_last[sel];
        end
    end

    // ID FIFO: grant pushes the winner, demux pops in packet order.
    assign push     = grant;
    assign pop      = id_valid && id_ready;
    assign id_valid = (count != '0);
    assign id_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ndata_packet_arbiter.sv
// Self-checking bench for ndata_packet_arbiter: queue-based sources and a
// transaction-level model of grants, lock ownership and the ID FIFO.
module tb_ndata_packet_arbiter;

    localparam int N     = 3;
    localparam int NE    = 4;
    localparam int DEPTH = 2;

    typedef logic [7:0] elem_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ndata_i #(.data_t(elem_t), .NUM_ELEMENTS(NE)) in_if [N] ();
    ndata_i #(.data_t(elem_t), .NUM_ELEMENTS(NE)) out_if ();

    logic [1:0]   id_data;
    logic         id_valid;
    logic         id_ready = 1'b0;
    logic         out_ready = 1'b0;
    logic         src_valid [N];
    logic [31:0]  src_data  [N];
    logic [3:0]   src_keep  [N];
    logic         src_last  [N];
    logic [N-1:0] in_rdy;

    for (genvar g = 0; g < N; g++) begin : g_src
        assign in_if[g].valid = src_valid[g];
        assign in_if[g].data  = src_data[g];
        assign in_if[g].keep  = src_keep[g];
        assign in_if[g].last  = src_last[g];
        assign in_rdy[g]      = in_if[g].ready;
    end
    assign out_if.ready = out_ready;

    ndata_packet_arbiter #(
        .data_t(elem_t), .NUM_ELEMENTS(NE), .NUM_INPUTS(N), .ID_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_if), .out(out_if),
        .id_data(id_data), .id_valid(id_valid), .id_ready(id_ready)
    );

    // Reference model state: pending beats per source, current owner, priority, ID queue.
    beat_t srcq [N][$];
    bit    en [N];
    int    owner = -1;
    int    prio = 0;
    int    idq[$];
    int    grant_log[$];

    int vectors = 0;
    int miscompares = 0;
    logic [43:0] obs;
    logic [43:0] expv;

    function automatic beat_t mk(logic [31:0] d, logic [3:0] k, logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    task automatic add_packet(int src, int len);
        for (int j = 0; j < len; j++)
            srcq[src].push_back(mk($urandom, 4'($urandom), (j == len - 1)));
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = en[i] && (srcq[i].size() > 0);
            if (srcq[i].size() > 0) begin
                src_data[i] = srcq[i][0].data;
                src_keep[i] = srcq[i][0].keep;
                src_last[i] = srcq[i][0].last;
            end else begin
                src_data[i] = '0;
                src_keep[i] = '0;
                src_last[i] = 1'b0;
            end
        end
    endtask

    // Drives sources, settles, and fills obs (DUT) and expv (model) for the current cycle.
    task automatic sample();
        logic         ev;
        logic [N-1:0] er;
        beat_t        b;
        logic         eidv;
        logic [1:0]   eid;
        drive_src();
        #1;
        ev = (owner >= 0) && src_valid[owner];
        er = '0;
        if (owner >= 0 && out_ready) er[owner] = 1'b1;
        b = ev ? srcq[owner][0] : '0;
        eidv = (idq.size() > 0);
        eid = eidv ? 2'(idq[0]) : 2'b0;
        expv = {ev, er, eidv, eid, b};
        obs = {out_if.valid, in_rdy, id_valid, (id_valid ? id_data : 2'b0),
               (out_if.valid ? {out_if.data, out_if.keep, out_if.last} : 37'b0)};
    endtask

    task automatic advance();
        bit full;
        bit hs;
        int g;
        int o;
        full = (idq.size() >= DEPTH);
        o = owner;
        hs = (o >= 0) && src_valid[o] && out_ready;
        g = -1;
        if (o < 0 && !full)
            for (int k = 0; k < N; k++)
                if (g < 0 && src_valid[(prio + k) % N]) g = (prio + k) % N;
        @(posedge clk);
        if (!rst_n) begin
            owner = -1;
            prio = 0;
            idq.delete();
            for (int i = 0; i < N; i++) srcq[i].delete();
        end else begin
            if (hs) begin
                if (srcq[o][0].last) owner = -1;
                void'(srcq[o].pop_front());
            end
            if (idq.size() > 0 && id_ready) void'(idq.pop_front());
            if (g >= 0) begin
                owner = g;
                prio = (g + 1) % N;
                idq.push_back(g);
                grant_log.push_back(g);
            end
        end
        @(negedge clk);
    endtask

    function automatic bit busy();
        bit b = (owner >= 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        out_ready = 1'b1;
        id_ready = 1'b0;
        rst_n = 1'b0;
        drive_src();
        advance();
        advance();
        rst_n = 1'b1;
        grant_log.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            sample();
            vectors++;
            if (obs !== expv || obs !== 44'd0) begin
                miscompares++;
                $display("FAIL reset c%0d: got %h, want %h", c, obs, expv);
            end
            advance();
        end
    endtask

    task automatic test_single_source();
        int beats = 0;
        int first = -1;
        int pops = 0;
        do_reset();
        srcq[0].push_back(mk(32'h11223344, 4'hF, 1'b0));
        srcq[0].push_back(mk(32'h55667788, 4'hF, 1'b0));
        srcq[0].push_back(mk(32'h99AABBCC, 4'h3, 1'b1));
        en[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            id_ready = (c >= 4);
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL single c%0d: got %h, want %h", c, obs, expv);
            end
            if (out_if.valid && out_ready) begin
                beats++;
                if (first < 0) first = c;
            end
            if (id_valid && id_ready && id_data == 2'd0) pops++;
            advance();
        end
        vectors++;
        if (beats != 3 || first != 1 || pops != 1) begin
            miscompares++;
            $display("FAIL single_summary: beats=%0d first=%0d pops=%0d, want 3 1 1", beats, first, pops);
        end
    endtask

    task automatic test_round_robin();
        int pops[$];
        int c = 0;
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) add_packet(i, 2);
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        id_ready = 1'b1;
        while ((busy() || idq.size() > 0) && c < 60) begin
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL rr c%0d: got %h, want %h", c, obs, expv);
            end
            if (id_valid && id_ready) pops.push_back(int'(id_data));
            advance();
            c++;
        end
        vectors++;
        if (pops.size() != 6) begin
            miscompares++;
            $display("FAIL rr_count: got %0d ids, want 6", pops.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (pops[k] != exp_order[k]) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: got %0d, want %0d", k, pops[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bit pat[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        add_packet(1, 4);
        en[1] = 1'b1;
        id_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            out_ready = pat[c % 4];
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL backpressure c%0d: got %h, want %h", c, obs, expv);
            end
            if (out_if.valid && out_ready) acc++;
            advance();
        end
        vectors++;
        if (acc != 4) begin
            miscompares++;
            $display("FAIL bp_beats: got %0d, want 4", acc);
        end
    endtask

    task automatic test_fifo_full();
        int rdy_blocked = 0;
        int rdy_after = 0;
        do_reset();
        add_packet(0, 1);
        add_packet(2, 1);
        en[0] = 1'b1;
        en[2] = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c == 5) begin
                add_packet(1, 1);
                en[1] = 1'b1;
            end
            id_ready = (c == 9);
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL fifo_full c%0d: got %h, want %h", c, obs, expv);
            end
            if (c < 10 && in_rdy[1]) rdy_blocked++;
            if (c >= 10 && in_rdy[1]) rdy_after++;
            advance();
        end
        vectors++;
        if (rdy_blocked != 0 || rdy_after != 1) begin
            miscompares++;
            $display("FAIL fifo_full_grant: ready blocked=%0d after=%0d, want 0 1", rdy_blocked, rdy_after);
        end
    endtask

    task automatic test_wrap();
        int pops[$];
        int c = 0;
        do_reset();
        for (int k = 0; k < 20; k++) add_packet($urandom_range(0, N - 1), 1);
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        id_ready = 1'b1;
        while ((busy() || idq.size() > 0) && c < 200) begin
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL wrap c%0d: got %h, want %h", c, obs, expv);
            end
            if (id_valid && id_ready) pops.push_back(int'(id_data));
            advance();
            c++;
        end
        vectors++;
        if (pops.size() != 20 || grant_log.size() != 20) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d ids, %0d grants, want 20", pops.size(), grant_log.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                vectors++;
                if (pops[k] != grant_log[k]) begin
                    miscompares++;
                    $display("FAIL wrap_id[%0d]: got %0d, want %0d", k, pops[k], grant_log[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int first_id = -1;
        do_reset();
        add_packet(0, 4);
        add_packet(1, 1);
        en[0] = 1'b1;
        en[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rst_n = (c != 2);
            if (c == 4) begin
                add_packet(1, 1);
                add_packet(0, 1);
            end
            id_ready = (c >= 4);
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL mid_reset c%0d: got %h, want %h", c, obs, expv);
            end
            if (c == 3) begin
                vectors++;
                if (out_if.valid !== 1'b0 || id_valid !== 1'b0 || in_rdy !== '0) begin
                    miscompares++;
                    $display("FAIL mid_reset_idle: valid=%b id_valid=%b ready=%b, want 0 0 000",
                             out_if.valid, id_valid, in_rdy);
                end
            end
            if (id_valid && id_ready && first_id < 0) first_id = int'(id_data);
            advance();
        end
        rst_n = 1'b1;
        vectors++;
        if (first_id != 0) begin
            miscompares++;
            $display("FAIL mid_reset_prio: got first id %0d, want 0", first_id);
        end
    endtask

    task automatic test_random();
        int c = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 6 && $urandom_range(0, 3) == 0) add_packet(i, $urandom_range(1, 4));
                en[i] = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 2) != 0);
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random c%0d: got %h, want %h", k, obs, expv);
            end
            advance();
        end
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        out_ready = 1'b1;
        id_ready = 1'b1;
        while ((busy() || idq.size() > 0) && c < 300) begin
            sample();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random_drain c%0d: got %h, want %h", c, obs, expv);
            end
            advance();
            c++;
        end
        vectors++;
        if (busy() || idq.size() > 0) begin
            miscompares++;
            $display("FAIL random_drain_timeout: got still busy after %0d cycles, want drained", c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
